// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller:
// opcodes, ALUOp codes, state codes and the control-word bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_j     = 6'b000010;
  localparam logic [5:0] op_addi  = 6'b001000;

  localparam logic [1:0] aluop_add   = 2'b00;
  localparam logic [1:0] aluop_sub   = 2'b01;
  localparam logic [1:0] aluop_funct = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == op_rtype) || (op == op_lw) || (op == op_sw) ||
           (op == op_beq) || (op == op_j) || (op == op_addi);
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Moore decoder: current state to raw control word,
// before mem_rdy gating and reset gating.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = aluop_add;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.alu_op    = aluop_add;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = aluop_add;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.done       = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
        ctrl_o.done      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = aluop_funct;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = aluop_sub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 2'b01;
        ctrl_o.done          = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = 2'b10;
        ctrl_o.done      = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = aluop_add;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.done      = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next-state,
// mem_rdy stall gating, PCEn and reset gating of all outputs.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_rdy,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  raw;
  logic   in_fetch, in_memwr;
  logic   pc_write, ir_write, done, ill;

  mc_ctrl_dec u_dec (
    .state_i (state_q),
    .ctrl_o  (raw)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (Op == op_lw || Op == op_sw) state_d = S_MEMADR;
        else if (Op == op_rtype)        state_d = S_EXEC;
        else if (Op == op_beq)          state_d = S_BRANCH;
        else if (Op == op_j)            state_d = S_JUMP;
        else if (Op == op_addi)         state_d = S_ADDIEX;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: state_d = (Op == op_lw) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Fetch and store completion only take effect once memory answers.
  assign in_fetch = (state_q == S_FETCH);
  assign in_memwr = (state_q == S_MEMWR);
  assign pc_write = raw.pc_write & (~in_fetch | mem_rdy);
  assign ir_write = raw.ir_write & mem_rdy;
  assign done     = raw.done & (~in_memwr | mem_rdy);
  assign ill      = (state_q == S_DECODE) & ~op_legal(Op);

  assign PCEn       = rstn & (pc_write | (raw.pc_write_cond & Zero));
  assign IorD       = rstn & raw.iord;
  assign MemRead    = rstn & raw.mem_read;
  assign MemWrite   = rstn & raw.mem_write;
  assign IRWrite    = rstn & ir_write;
  assign RegDst     = rstn & raw.reg_dst;
  assign MemtoReg   = rstn & raw.mem_to_reg;
  assign RegWrite   = rstn & raw.reg_write;
  assign ALUSrcA    = rstn & raw.alu_src_a;
  assign ALUSrcB    = rstn ? raw.alu_src_b : 2'b00;
  assign ALUOp      = rstn ? raw.alu_op : 2'b00;
  assign PCSource   = rstn ? raw.pc_source : 2'b00;
  assign instr_done = rstn & done;
  assign illegal    = rstn & ill;
  assign state      = rstn ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: expected control words are queued
// as each cycle is driven and checked at the following falling edge.
module tb_mc_ctrl;

  logic       clk = 1'b1;
  logic       rstn, Zero, mem_rdy;
  logic [5:0] op;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst;
  logic       MemtoReg, RegWrite, ALUSrcA, instr_done, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  typedef struct {
    string       tag;
    logic [20:0] w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rstn(rstn), .Op(op), .Zero(Zero), .mem_rdy(mem_rdy),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  // Reference control word straight from the state table.
  function automatic logic [20:0] exp_w(input logic [3:0] st,
      input logic rs, input logic rdy, input logic z,
      input logic [5:0] o);
    logic pcen, iord, mr, mw, irw, rd, m2r, rw, sa, dn, il;
    logic [1:0] sb, ao, ps;
    logic legal;
    {pcen, iord, mr, mw, irw, rd, m2r, rw, sa, dn, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    legal = (o == 6'b000000) || (o == 6'b100011) ||
            (o == 6'b101011) || (o == 6'b000100) ||
            (o == 6'b000010) || (o == 6'b001000);
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pcen = rdy; end
      4'd1:  begin sb = 2'b11; il = !legal; end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; dn = 1; end
      4'd5:  begin mw = 1; iord = 1; dn = rdy; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; dn = 1; pcen = z; end
      4'd9:  begin pcen = 1; ps = 2'b10; dn = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    if (!rs) return '0;
    return {st, pcen, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps,
            dn, il};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [20:0] obs;
    if (q.size() > 0) begin
      e = q.pop_front();
      obs = {state, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             instr_done, illegal};
      checks++;
      assert (obs === e.w) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.w);
      end
    end
  end

  task automatic step(input logic [3:0] st, input string tag);
    exp_t e;
    e.tag = tag;
    e.w   = exp_w(st, rstn, mem_rdy, Zero, op);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; Zero = 1'b0; mem_rdy = 1'b1; op = 6'b100011;
    step(4'd0, "rst0");
    step(4'd0, "rst1");
    step(4'd0, "rst2");
    rstn = 1'b1;
    // lw, no stalls: 5 cycles
    step(4'd0, "lw_fetch");
    step(4'd1, "lw_dec");
    step(4'd2, "lw_adr");
    step(4'd3, "lw_rd");
    step(4'd4, "lw_wb");
    // sw with a fetch stall and two write stalls
    op = 6'b101011; mem_rdy = 1'b0;
    step(4'd0, "sw_fetch_stall");
    mem_rdy = 1'b1;
    step(4'd0, "sw_fetch");
    step(4'd1, "sw_dec");
    step(4'd2, "sw_adr");
    mem_rdy = 1'b0;
    step(4'd5, "sw_wr_stall0");
    step(4'd5, "sw_wr_stall1");
    mem_rdy = 1'b1;
    step(4'd5, "sw_wr_rdy");
    // beq taken then not taken
    op = 6'b000100; Zero = 1'b1;
    step(4'd0, "beq1_fetch");
    step(4'd1, "beq1_dec");
    step(4'd8, "beq1_taken");
    Zero = 1'b0;
    step(4'd0, "beq0_fetch");
    step(4'd1, "beq0_dec");
    step(4'd8, "beq0_nottaken");
    // R-type, addi, j
    op = 6'b000000;
    step(4'd0, "r_fetch");
    step(4'd1, "r_dec");
    step(4'd6, "r_exec");
    step(4'd7, "r_wb");
    op = 6'b001000;
    step(4'd0, "addi_fetch");
    step(4'd1, "addi_dec");
    step(4'd10, "addi_ex");
    step(4'd11, "addi_wb");
    op = 6'b000010; Zero = 1'b1;
    step(4'd0, "j_fetch");
    step(4'd1, "j_dec");
    step(4'd9, "j_jump");
    Zero = 1'b0;
    // unsupported opcode
    op = 6'b111111;
    step(4'd0, "ill_fetch");
    step(4'd1, "ill_dec");
    // reset while stalled in MEMRD
    op = 6'b100011;
    step(4'd0, "abort_fetch");
    step(4'd1, "abort_dec");
    step(4'd2, "abort_adr");
    mem_rdy = 1'b0;
    step(4'd3, "abort_rd_stall");
    rstn = 1'b0;
    step(4'd0, "abort_in_reset");
    rstn = 1'b1; mem_rdy = 1'b1;
    step(4'd0, "abort_refetch");
    step(4'd1, "abort_dec2");
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It generates every datapath enable and mux select, plus the 2-bit ALUOp that drives the ALU-control decoder. Memory accesses stall on a ready handshake.

## Interface
- No parameters. Opcodes, ALUOp codes and state codes are fixed defines.
- clk  in  1  system clock; all state updates on the rising edge
- rstn  in  1  synchronous, active-low reset
- Op  in  6  instruction[31:26] from the instruction register
- Zero  in  1  ALU zero flag
- mem_rdy  in  1  memory has completed the current read/write this cycle
- PCEn  out  1  PC load = PCWrite | (PCWriteCond & Zero)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead / MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  write data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  A input: 0 = PC, 1 = rs
- ALUSrcB  out  2  B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = use funct
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE when Op is unsupported
- state  out  4  current state, for debug

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Outputs are Moore-decoded from the state. The only exceptions are the mem_rdy gating below and PCEn, which also depends on Zero.
- FETCH:
  - Asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_rdy=1.
  - Stays in FETCH while mem_rdy=0; goes to DECODE when mem_rdy=1.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch-target precompute).
  - Next state by Op: lw/sw → MEMADR; R → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX.
  - Any other Op → FETCH, with illegal pulsed for that cycle.
- MEMADR:
  - Asserts ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: lw → MEMRD, sw → MEMWR.
- MEMRD:
  - Asserts MemRead and IorD=1.
  - Holds until mem_rdy=1, then goes to MEMWB.
- MEMWB:
  - Asserts RegWrite, RegDst=0, MemtoReg=1, instr_done.
  - Next: FETCH.
- MEMWR:
  - Asserts MemWrite and IorD=1.
  - Holds until mem_rdy=1; instr_done pulses in the cycle mem_rdy=1.
  - Next: FETCH.
- EXEC: asserts ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: asserts RegWrite, RegDst=1, MemtoReg=0, instr_done. Next: FETCH.
- BRANCH:
  - Asserts ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, instr_done.
  - Next: FETCH.
- JUMP: asserts PCWrite, PCSource=10, instr_done. Next: FETCH.
- ADDIEX: asserts ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB: asserts RegWrite, RegDst=0, MemtoReg=0, instr_done. Next: FETCH.
- Unused codes 12–15 go to FETCH next cycle with all write enables deasserted.
- Any output not listed for a state is 0.

## Timing
- Reset:
  - A clock edge with rstn=0 loads state=FETCH.
  - While rstn=0, every output is 0 (gated combinationally), including PCEn, MemRead, IRWrite and the pulses.
  - In the first cycle after rstn rises, the block is in FETCH.
- Cycle counts with mem_rdy held at 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of mem_rdy=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. MemRead/MemWrite and IorD stay stable throughout the stall.
- PCEn in BRANCH follows Zero in the same cycle. In every other state it equals PCWrite.
- Reset asserted mid-instruction, in any state, aborts the instruction. No write enable fires on that edge.

## Structure
- Add to the shared ctrl_encode_def.v header:
  - opcode defines (op_rtype, op_lw, op_sw, op_beq, op_j, op_addi);
  - ALUOp codes (aluop_add=00, aluop_sub=01, aluop_funct=10);
  - the 12 state codes.
- One sub-module, mc_ctrl_dec: a purely combinational state → control-word decoder.
- The top module holds the state register, next-state logic, mem_rdy gating, PCEn and reset gating.

## Test plan
- Reset: rstn=0 for 3 cycles → all outputs 0. After release: state=0, MemRead=1; with mem_rdy=1, IRWrite=1 and PCEn=1.
- lw (Op=100011), mem_rdy=1 → states 0,1,2,3,4. MemWB asserts RegWrite=1 and MemtoReg=1. instr_done pulses only at cycle 5.
- sw with mem_rdy=0 for 2 cycles in MEMWR → MemWrite=1 and IorD=1 for 3 cycles. instr_done fires on the rdy cycle. Total 6 cycles. RegWrite is never asserted.
- beq:
  - Zero=1 → PCEn=1, PCSource=01, ALUOp=01 in state 8.
  - Zero=0 → PCEn=0.
  - Both cases return to FETCH.
- R-type then addi then j → ALUOp=10 in EXEC with RegDst=1; ALUSrcB=10 in ADDIEX with RegDst=0; PCSource=10 and PCEn=1 in JUMP.
- Op=111111 → illegal=1 in DECODE, next state FETCH, no RegWrite/MemWrite/PCEn. Separately: rstn dropped in MEMRD → state=0 next cycle, MemRead=0 while in reset.
